// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, lock-state encoding and a window helper shared
// by the monitor and the display driver.
package vga_timing_pkg;

  localparam int VGA_H_DISP  = 640;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_V_DISP  = 480;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_TOTAL = 525;

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_HSYNCED = 2'd1,
    ST_FRAMED  = 2'd2,
    ST_LOCKED  = 2'd3
  } lock_state_t;

  function automatic logic in_window(input logic [10:0] idx, input int lo, input int len);
    return (int'(idx) >= lo) && (int'(idx) < lo + len);
  endfunction

endpackage

// File: rtl/vga_frame_sum.sv
// Frame checksum: sums the active pixels of the running frame and latches the
// total at each frame start, restarting with the frame-start pixel itself.
module vga_frame_sum (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic [11:0] rgb,
  input  logic        frame_start,
  output logic [15:0] frame_sum
);

  logic [15:0] acc_reg;
  logic [15:0] pixel;

  assign pixel = de ? {4'd0, rgb} : 16'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      frame_sum <= '0;
    end else if (frame_start) begin
      frame_sum <= acc_reg;
      acc_reg   <= pixel;
    end else begin
      acc_reg <= acc_reg + pixel;
    end
  end

endmodule

// File: rtl/vga_monitor.sv
// Passive VGA stream monitor: recovers pixel coordinates from hs/vs, measures
// line/frame timing against the parameters and tracks lock plus a frame checksum.
module vga_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_DISP  = VGA_H_DISP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BACK  = VGA_H_BACK,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_DISP  = VGA_V_DISP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BACK  = VGA_V_BACK,
  parameter int V_TOTAL = VGA_V_TOTAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [11:0] vga_rgb,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_de,
  output logic [11:0] px_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [10:0] h_total_meas,
  output logic [9:0]  v_total_meas,
  output logic        timing_err
);

  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  logic        hs_reg;
  logic        vs_reg;
  logic [10:0] h_cnt_reg;
  logic [10:0] hs_width_reg;
  logic [9:0]  v_cnt_reg;
  logic [9:0]  vs_width_reg;
  logic        frame_pend_reg;
  logic        frame_ok_reg;
  logic [1:0]  good_cnt_reg;
  logic [1:0]  good_cnt_next;
  lock_state_t state_reg;

  logic        hs_fall;
  logic        hs_rise;
  logic        vs_fall;
  logic        frame_start;
  logic        h_seen;
  logic        framed;
  logic        h_bad;
  logic        v_bad;
  logic        mismatch;
  logic        frame_good;
  logic        de_next;
  logic [10:0] h_idx;
  logic [10:0] v_total_next;

  always_comb begin
    hs_fall      = hs_reg & ~vga_hs;
    hs_rise      = ~hs_reg & vga_hs;
    vs_fall      = vs_reg & ~vga_vs;
    // A vs fall coinciding with the hs fall is consumed immediately.
    frame_start  = hs_fall & (frame_pend_reg | vs_fall);
    // The sample at the hs fall is column 0 even though h_cnt still holds the old line length.
    h_idx        = hs_fall ? 11'd0 : h_cnt_reg;
    h_seen       = (state_reg != ST_UNSYNC);
    framed       = (state_reg == ST_FRAMED) || (state_reg == ST_LOCKED);
    v_total_next = {1'b0, v_cnt_reg} + 11'd1;
    h_bad        = hs_fall & h_seen &
                   ((int'(h_cnt_reg) != H_TOTAL) | (int'(hs_width_reg) != H_SYNC));
    v_bad        = frame_start & framed &
                   ((int'(v_total_next) != V_TOTAL) | (int'(vs_width_reg) != V_SYNC));
    mismatch     = h_bad | v_bad;
    frame_good   = frame_start & framed & frame_ok_reg & ~mismatch;
    de_next      = framed & in_window(h_idx, H_START, H_DISP) &
                   in_window({1'b0, v_cnt_reg}, V_START, V_DISP);
    good_cnt_next = good_cnt_reg;
    if (mismatch)
      good_cnt_next = 2'd0;
    else if (frame_good && good_cnt_reg != 2'd2)
      good_cnt_next = good_cnt_reg + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_reg         <= 1'b0;
      vs_reg         <= 1'b0;
      h_cnt_reg      <= '0;
      hs_width_reg   <= '0;
      v_cnt_reg      <= '0;
      vs_width_reg   <= '0;
      frame_pend_reg <= 1'b0;
      px_x           <= '0;
      px_y           <= '0;
      px_de          <= 1'b0;
      px_rgb         <= '0;
      frame_done     <= 1'b0;
      h_total_meas   <= '0;
      v_total_meas   <= '0;
    end else begin
      hs_reg <= vga_hs;
      vs_reg <= vga_vs;

      if (hs_fall)
        h_cnt_reg <= 11'd1;
      else if (h_cnt_reg != 11'd2047)
        h_cnt_reg <= h_cnt_reg + 11'd1;

      if (hs_fall)
        h_total_meas <= h_cnt_reg;
      if (hs_rise)
        hs_width_reg <= h_cnt_reg;

      if (frame_start) begin
        v_cnt_reg      <= '0;
        v_total_meas   <= v_total_next[9:0];
        vs_width_reg   <= 10'd1;
        frame_pend_reg <= 1'b0;
      end else begin
        if (hs_fall && v_cnt_reg != 10'd1023)
          v_cnt_reg <= v_cnt_reg + 10'd1;
        if (hs_fall && !vga_vs && vs_width_reg != 10'd1023)
          vs_width_reg <= vs_width_reg + 10'd1;
        if (vs_fall)
          frame_pend_reg <= 1'b1;
      end

      px_x       <= 10'(h_idx - 11'(H_START));
      px_y       <= v_cnt_reg - 10'(V_START);
      px_de      <= de_next;
      px_rgb     <= vga_rgb;
      frame_done <= frame_start;
    end
  end

  // Lock tracker: any mismatch drops back to FRAMED and restarts the good-frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_UNSYNC;
      good_cnt_reg <= '0;
      frame_ok_reg <= 1'b0;
      locked       <= 1'b0;
      timing_err   <= 1'b0;
    end else begin
      timing_err   <= mismatch;
      good_cnt_reg <= good_cnt_next;
      if (frame_start)
        frame_ok_reg <= 1'b1;
      else if (mismatch)
        frame_ok_reg <= 1'b0;

      case (state_reg)
        ST_UNSYNC: begin
          if (frame_start)
            state_reg <= ST_FRAMED;
          else if (hs_fall)
            state_reg <= ST_HSYNCED;
        end
        ST_HSYNCED: begin
          if (frame_start)
            state_reg <= ST_FRAMED;
        end
        ST_FRAMED: begin
          if (good_cnt_next == 2'd2) begin
            state_reg <= ST_LOCKED;
            locked    <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (mismatch) begin
            state_reg <= ST_FRAMED;
            locked    <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_UNSYNC;
          locked    <= 1'b0;
        end
      endcase
    end
  end

  vga_frame_sum u_frame_sum (
    .clk         (clk),
    .rst         (rst),
    .de          (de_next),
    .rgb         (vga_rgb),
    .frame_start (frame_start),
    .frame_sum   (frame_sum)
  );

endmodule
